// File: rtl/sim_activity_watchdog.sv
// sim_activity_watchdog
//   Multi-channel simulation watchdog. It flags runs that hang by watching per-channel
//   activity strobes. It can also enforce an optional global budget of armed cycles.
//   A trigger starts a grace period so that logs and the UART can drain. After the grace
//   period a sticky timeout is raised and a one-time diagnostic line is printed.
//
//   Optional build macro: SIM_WATCHDOG_FINISH_EN. When it is defined, the watchdog calls
//   $finish right after the expiry report. When it is undefined (the default), timeout_o
//   simply stays high for the surrounding bench to act on.
//
// Ports
//   clock                simulation clock
//   reset                synchronous, active-high reset
//   enable               arms the watchdog while high
//   channel_mask         1 = channel monitored
//   activity             per-channel activity strobe
//   kick                 clears all idle counters (global counter untouched)
//   triggered_o          high from trigger until reset
//   timeout_o            sticky expiry flag
//   global_expired_o     expiry caused by the global cycle budget
//   timed_out_channel_o  channel that caused an idle expiry
//   elapsed_cycles_o     armed-cycle count, saturating, frozen at trigger

module sim_activity_watchdog #(
   parameter int unsigned CHANNEL_COUNT = 4,
   parameter int unsigned CH_IDX_WIDTH  = 2,
   parameter int unsigned COUNTER_WIDTH = 32,
   parameter int unsigned IDLE_LIMIT    = 100000,
   parameter int unsigned GLOBAL_LIMIT  = 0,
   parameter int unsigned GRACE_CYCLES  = 16
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     enable,
   input  logic [CHANNEL_COUNT-1:0] channel_mask,
   input  logic [CHANNEL_COUNT-1:0] activity,
   input  logic                     kick,
   output logic                     triggered_o,
   output logic                     timeout_o,
   output logic                     global_expired_o,
   output logic [CH_IDX_WIDTH-1:0]  timed_out_channel_o,
   output logic [COUNTER_WIDTH-1:0] elapsed_cycles_o
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ARMED   = 2'd1;
   localparam logic [1:0] ST_GRACE   = 2'd2;
   localparam logic [1:0] ST_EXPIRED = 2'd3;

   localparam logic [COUNTER_WIDTH-1:0] IDLE_LIM     = COUNTER_WIDTH'(IDLE_LIMIT);
   localparam logic [COUNTER_WIDTH-1:0] IDLE_LIM_M1  = COUNTER_WIDTH'(IDLE_LIMIT - 1);
   localparam logic [COUNTER_WIDTH-1:0] GLOBAL_LIM_M1 = COUNTER_WIDTH'(GLOBAL_LIMIT - 1);
   localparam logic [COUNTER_WIDTH-1:0] GRACE_M1     = COUNTER_WIDTH'(GRACE_CYCLES - 1);
   localparam logic                     GLOBAL_EN    = (GLOBAL_LIMIT != 0);
   localparam logic                     NO_GRACE     = (GRACE_CYCLES == 0);

   logic [1:0]               r_state;
   logic [COUNTER_WIDTH-1:0] r_idle_cnt [CHANNEL_COUNT];
   logic [COUNTER_WIDTH-1:0] r_elapsed;
   logic [COUNTER_WIDTH-1:0] r_grace_cnt;
   logic                     r_triggered;
   logic                     r_timeout;
   logic                     r_global;
   logic [CH_IDX_WIDTH-1:0]  r_channel;

   logic [COUNTER_WIDTH-1:0] w_elapsed_inc;
   logic [COUNTER_WIDTH-1:0] w_idle_next [CHANNEL_COUNT];
   logic [CHANNEL_COUNT-1:0] w_idle_hit;
   logic [CH_IDX_WIDTH-1:0]  w_hit_idx;
   logic                     w_any_idle;
   logic                     w_global_hit;
   logic                     w_trig_now;
   logic                     w_enter_exp;
   logic                     w_rep_global;
   logic [CH_IDX_WIDTH-1:0]  w_rep_channel;
   logic [COUNTER_WIDTH-1:0] w_rep_elapsed;

   always_comb begin
      w_elapsed_inc = (r_elapsed == '1) ? r_elapsed : r_elapsed + COUNTER_WIDTH'(1);
      w_hit_idx     = '0;
      w_idle_hit    = '0;
      for (int i = 0; i < int'(CHANNEL_COUNT); i++) begin
         if (activity[i] || kick || !channel_mask[i]) begin
            w_idle_next[i] = '0;
         end else begin
            w_idle_next[i] = (r_idle_cnt[i] >= IDLE_LIM) ? IDLE_LIM
                                                         : r_idle_cnt[i] + COUNTER_WIDTH'(1);
            // Trigger on the cycle whose update would bring the count to the limit.
            w_idle_hit[i]  = (r_idle_cnt[i] >= IDLE_LIM_M1);
         end
      end
      // Walk downwards so the lowest-index hit ends up in w_hit_idx.
      for (int i = int'(CHANNEL_COUNT) - 1; i >= 0; i--) begin
         if (w_idle_hit[i]) w_hit_idx = CH_IDX_WIDTH'(i);
      end
      w_any_idle   = |w_idle_hit;
      w_global_hit = GLOBAL_EN && (r_elapsed == GLOBAL_LIM_M1);
      w_trig_now   = (r_state == ST_ARMED) && enable && (w_any_idle || w_global_hit);
      w_enter_exp  = (w_trig_now && NO_GRACE)
                  || ((r_state == ST_GRACE) && (r_grace_cnt == GRACE_M1));

      // Cause and count printed on entry to EXPIRED, valid whichever path leads there.
      if (w_trig_now) begin
         w_rep_global  = !w_any_idle;
         w_rep_channel = w_any_idle ? w_hit_idx : '0;
         w_rep_elapsed = w_elapsed_inc;
      end else begin
         w_rep_global  = r_global;
         w_rep_channel = r_channel;
         w_rep_elapsed = r_elapsed;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_elapsed   <= '0;
         r_grace_cnt <= '0;
         r_triggered <= 1'b0;
         r_timeout   <= 1'b0;
         r_global    <= 1'b0;
         r_channel   <= '0;
         for (int i = 0; i < int'(CHANNEL_COUNT); i++) r_idle_cnt[i] <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (enable) r_state <= ST_ARMED;
            end
            ST_ARMED: begin
               if (!enable) begin
                  r_state   <= ST_IDLE;
                  r_elapsed <= '0;
                  for (int i = 0; i < int'(CHANNEL_COUNT); i++) r_idle_cnt[i] <= '0;
               end else begin
                  r_elapsed <= w_elapsed_inc;
                  for (int i = 0; i < int'(CHANNEL_COUNT); i++) r_idle_cnt[i] <= w_idle_next[i];
                  if (w_trig_now) begin
                     r_triggered <= 1'b1;
                     r_global    <= w_rep_global;
                     r_channel   <= w_rep_channel;
                     r_grace_cnt <= '0;
                     if (NO_GRACE) begin
                        r_state   <= ST_EXPIRED;
                        r_timeout <= 1'b1;
                     end else begin
                        r_state <= ST_GRACE;
                     end
                  end
               end
            end
            ST_GRACE: begin
               // Inputs are ignored here: a trigger cannot be withdrawn.
               if (w_enter_exp) begin
                  r_state   <= ST_EXPIRED;
                  r_timeout <= 1'b1;
               end else begin
                  r_grace_cnt <= r_grace_cnt + COUNTER_WIDTH'(1);
               end
            end
            ST_EXPIRED: begin
               r_state <= ST_EXPIRED;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // One-shot diagnostic on entry to EXPIRED; EXPIRED is terminal so this fires once.
   always_ff @(posedge clock) begin
      if (!reset && w_enter_exp) begin
         if (w_rep_global) begin
            $display("Simulation watchdog expired: cause=global budget, elapsed_cycles=%0d",
                     w_rep_elapsed);
         end else begin
            $display("Simulation watchdog expired: cause=idle channel %0d, elapsed_cycles=%0d",
                     w_rep_channel, w_rep_elapsed);
         end
`ifdef SIM_WATCHDOG_FINISH_EN
         $finish;
`else
`endif
      end
   end

   assign triggered_o         = r_triggered;
   assign timeout_o           = r_timeout;
   assign global_expired_o    = r_global;
   assign timed_out_channel_o = r_channel;
   assign elapsed_cycles_o    = r_elapsed;

endmodule

// File: tb/tb_sim_activity_watchdog.sv
// Bench for sim_activity_watchdog. It uses two instances that share one stimulus:
//   dut A: IDLE_LIMIT=10, GLOBAL_LIMIT=0,  GRACE_CYCLES=3
//   dut B: IDLE_LIMIT=10, GLOBAL_LIMIT=50, GRACE_CYCLES=0
// The reference model is timestamp based. It records the edge number at which the
// watchdog armed, the edge at which each channel was last cleared, and the edge at which
// the watchdog triggered. All outputs are derived from differences between edge numbers.

module tb_sim_activity_watchdog;

   localparam int IL = 10;
   localparam int GL [2] = '{0, 50};
   localparam int GR [2] = '{3, 0};

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic [3:0] channel_mask = '0;
   logic [3:0] activity = '0;
   logic       kick = 1'b0;

   logic        trig   [2];
   logic        tmo    [2];
   logic        glob   [2];
   logic [1:0]  chan   [2];
   logic [31:0] elap   [2];

   always #5 clock = ~clock;

   sim_activity_watchdog #(
      .CHANNEL_COUNT(4), .CH_IDX_WIDTH(2), .COUNTER_WIDTH(32),
      .IDLE_LIMIT(IL), .GLOBAL_LIMIT(0), .GRACE_CYCLES(3)
   ) u_dut_a (
      .clock(clock), .reset(reset), .enable(enable), .channel_mask(channel_mask),
      .activity(activity), .kick(kick), .triggered_o(trig[0]), .timeout_o(tmo[0]),
      .global_expired_o(glob[0]), .timed_out_channel_o(chan[0]), .elapsed_cycles_o(elap[0])
   );

   sim_activity_watchdog #(
      .CHANNEL_COUNT(4), .CH_IDX_WIDTH(2), .COUNTER_WIDTH(32),
      .IDLE_LIMIT(IL), .GLOBAL_LIMIT(50), .GRACE_CYCLES(0)
   ) u_dut_b (
      .clock(clock), .reset(reset), .enable(enable), .channel_mask(channel_mask),
      .activity(activity), .kick(kick), .triggered_o(trig[1]), .timeout_o(tmo[1]),
      .global_expired_o(glob[1]), .timed_out_channel_o(chan[1]), .elapsed_cycles_o(elap[1])
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int     edge_n = 0;
   bit     m_armed  [2];
   bit     m_done   [2];
   bit     m_gsrc   [2];
   int     m_ch     [2];
   int     m_arm    [2];
   int     m_trig_e [2];
   longint m_elap   [2];
   int     m_clr    [2][4];

   always @(posedge clock) begin
      edge_n++;
      for (int k = 0; k < 2; k++) begin
         if (reset) begin
            m_armed[k] = 0; m_done[k] = 0; m_gsrc[k] = 0; m_ch[k] = 0; m_elap[k] = 0;
         end else if (m_done[k]) begin
            // frozen after trigger until reset
         end else if (!m_armed[k]) begin
            if (enable) begin
               m_armed[k] = 1; m_arm[k] = edge_n; m_elap[k] = 0;
               for (int i = 0; i < 4; i++) m_clr[k][i] = edge_n;
            end
         end else if (!enable) begin
            m_armed[k] = 0; m_elap[k] = 0;
         end else begin
            int hit;
            bit ghit;
            hit = -1;
            m_elap[k] = edge_n - m_arm[k];
            if (m_elap[k] > 64'hFFFF_FFFF) m_elap[k] = 64'hFFFF_FFFF;
            for (int i = 0; i < 4; i++) begin
               if (activity[i] || kick || !channel_mask[i]) m_clr[k][i] = edge_n;
               else if ((edge_n - m_clr[k][i]) >= IL && hit < 0) hit = i;
            end
            ghit = (GL[k] != 0) && (m_elap[k] == longint'(GL[k]));
            if (hit >= 0 || ghit) begin
               m_done[k] = 1; m_trig_e[k] = edge_n;
               m_gsrc[k] = (hit < 0);
               m_ch[k]   = (hit < 0) ? 0 : hit;
            end
         end
      end
   end

   // Per-cycle comparison of every output of both instances.
   always @(negedge clock) begin
      if (edge_n >= 1) begin
         for (int k = 0; k < 2; k++) begin
            check($sformatf("dut%0d.triggered_o", k), 64'(trig[k]), 64'(m_done[k]));
            check($sformatf("dut%0d.timeout_o", k), 64'(tmo[k]),
                  64'(m_done[k] && (edge_n - m_trig_e[k] >= GR[k])));
            check($sformatf("dut%0d.global_expired_o", k), 64'(glob[k]),
                  64'(m_done[k] && m_gsrc[k]));
            check($sformatf("dut%0d.timed_out_channel_o", k), 64'(chan[k]),
                  64'((m_done[k] && !m_gsrc[k]) ? m_ch[k] : 0));
            check($sformatf("dut%0d.elapsed_cycles_o", k), 64'(elap[k]), 64'(m_elap[k]));
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1; enable = 1'b0; kick = 1'b0; activity = '0; channel_mask = '0;
      ticks(2);
      reset = 1'b0;
   endtask

   initial begin
      int dens [4];
      ticks(1);
      check("reset_a_trig", 64'(trig[0]), 64'd0);
      check("reset_a_elapsed", 64'(elap[0]), 64'd0);
      check("reset_b_timeout", 64'(tmo[1]), 64'd0);

      // 1: all channels silent from arm.
      do_reset();
      channel_mask = 4'hF; enable = 1'b1;
      ticks(1);
      ticks(9);
      check("t1_a_no_early_trig", 64'(trig[0]), 64'd0);
      ticks(1);
      check("t1_a_trig", 64'(trig[0]), 64'd1);
      check("t1_a_chan", 64'(chan[0]), 64'd0);
      check("t1_a_glob", 64'(glob[0]), 64'd0);
      check("t1_a_elapsed", 64'(elap[0]), 64'd10);
      check("t1_b_timeout_no_grace", 64'(tmo[1]), 64'd1);
      ticks(2);
      check("t1_a_timeout_in_grace", 64'(tmo[0]), 64'd0);
      ticks(1);
      check("t1_a_timeout", 64'(tmo[0]), 64'd1);

      // 2: channels 0,2,3 strobed every 5 cycles, channel 1 silent.
      do_reset();
      channel_mask = 4'hF; enable = 1'b1;
      ticks(1);
      for (int c = 1; c <= 10; c++) begin
         activity = (c % 5 == 0) ? 4'b1101 : 4'b0000;
         ticks(1);
         if (c == 9) check("t2_no_early_trig", 64'(trig[0]), 64'd0);
      end
      check("t2_trig", 64'(trig[0]), 64'd1);
      check("t2_chan", 64'(chan[0]), 64'd1);

      // 3: all channels busy, global budget on dut B.
      do_reset();
      channel_mask = 4'hF; activity = 4'hF; enable = 1'b1;
      ticks(1);
      ticks(49);
      check("t3_b_no_early", 64'(trig[1]), 64'd0);
      ticks(1);
      check("t3_b_trig", 64'(trig[1]), 64'd1);
      check("t3_b_glob", 64'(glob[1]), 64'd1);
      check("t3_b_elapsed", 64'(elap[1]), 64'd50);
      check("t3_a_no_trig", 64'(trig[0]), 64'd0);
      ticks(5);
      check("t3_b_elapsed_frozen", 64'(elap[1]), 64'd50);

      // 4: periodic kicks hold off the idle trigger.
      do_reset();
      channel_mask = 4'hF; enable = 1'b1;
      ticks(1);
      for (int c = 1; c <= 200; c++) begin
         kick = (c % 8 == 0);
         ticks(1);
      end
      kick = 1'b0;
      check("t4_kicked_no_trig", 64'(trig[0]), 64'd0);
      ticks(9);
      check("t4_no_early", 64'(trig[0]), 64'd0);
      ticks(1);
      check("t4_trig_after_kicks", 64'(trig[0]), 64'd1);

      // 5: channels 1 and 3 go idle together, then reset during grace.
      do_reset();
      channel_mask = 4'hF; activity = 4'b0101; enable = 1'b1;
      ticks(11);
      check("t5_chan_lowest", 64'(chan[0]), 64'd1);
      ticks(1);
      reset = 1'b1; enable = 1'b0;
      ticks(1);
      check("t5_reset_trig", 64'(trig[0]), 64'd0);
      check("t5_reset_chan", 64'(chan[0]), 64'd0);
      check("t5_reset_elapsed", 64'(elap[0]), 64'd0);
      reset = 1'b0;

      // 6: nothing monitored, then disarm.
      do_reset();
      enable = 1'b1;
      ticks(1001);
      check("t6_a_no_trig", 64'(trig[0]), 64'd0);
      check("t6_a_elapsed", 64'(elap[0]), 64'd1000);
      enable = 1'b0;
      ticks(1);
      check("t6_a_elapsed_cleared", 64'(elap[0]), 64'd0);

      // Randomized episodes.
      for (int e = 0; e < 12; e++) begin
         do_reset();
         channel_mask = 4'($urandom);
         for (int i = 0; i < 4; i++) begin
            case ($urandom_range(0, 4))
               0: dens[i] = 1;
               1: dens[i] = 3;
               2: dens[i] = 7;
               3: dens[i] = 15;
               default: dens[i] = 63;
            endcase
         end
         enable = 1'b1;
         for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < 4; i++)
               activity[i] = ($urandom_range(0, dens[i]) == 0);
            kick = ($urandom_range(0, 31) == 0);
            if (enable) enable = ($urandom_range(0, 63) != 0);
            else        enable = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 49) == 0) channel_mask = 4'($urandom);
            reset = ($urandom_range(0, 255) == 0);
            ticks(1);
         end
         reset = 1'b0;
      end

      ticks(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
